// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - mode codes and sizing helpers shared by the LED controller files
// Contents: mode_e display-mode codes, MODE_LAST, next_mode() press sequencing,
//           clog2() for counter sizing.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_CHASE = 3'd3,
    MODE_DIM   = 3'd4
  } mode_e;

  localparam logic [2:0] MODE_LAST = MODE_DIM;

  // Press sequence OFF -> ON -> BLINK -> CHASE -> DIM -> OFF; stray codes go to OFF.
  function automatic logic [2:0] next_mode(input logic [2:0] cur);
    case (cur)
      MODE_OFF:   next_mode = MODE_ON;
      MODE_ON:    next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_CHASE;
      MODE_CHASE: next_mode = MODE_DIM;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

  // ceil(log2(n)), never less than 1 so a counter always has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - push-button synchroniser, debounce counter and press pulse
// Ports: clk       fabric clock
//        resetn    synchronous active-low reset
//        pb_n      raw asynchronous button, 0 = pressed
//        press     one-cycle pulse on each accepted released->pressed change
module pb_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic pb_n,
  output logic press
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= pb_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level has disagreed long enough: accept it. Only the falling
        // (pressed) direction produces a pulse.
        deb   <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_ctrl_multi.sv
// rtl/led_ctrl_multi.sv - one-button, multi-LED display-mode controller
// Ports: CLK     fabric clock
//        RESETn  synchronous active-low reset
//        PB_SW   raw asynchronous push button, 0 = pressed
//        LED     registered LED drive, 1 = lit
//        MODE    registered current mode code
//        PRESS   one-cycle pulse on each accepted press
module led_ctrl_multi
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 12500000,
  parameter int PWM_BITS        = 4,
  parameter int PWM_DUTY        = 4
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                PB_SW,
  output logic [NUM_LEDS-1:0] LED,
  output logic [2:0]          MODE,
  output logic                PRESS
);

  localparam int TW = clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
  // One bit wider than the PWM counter so a duty of 2^PWM_BITS means always on.
  localparam logic [PWM_BITS:0] DUTY = (PWM_BITS + 1)'(PWM_DUTY);

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [2:0]          led_mode;   // mode the LED register currently displays
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_nxt;
  logic [NUM_LEDS-1:0] rot;

  pb_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pb_debounce (
    .clk    (CLK),
    .resetn (RESETn),
    .pb_n   (PB_SW),
    .press  (PRESS)
  );

  assign tick    = (tick_cnt == TICK_MAX);
  assign pwm_nxt = pwm_cnt + 1'b1;

  // Rotate left with MSB wrapping to bit 0; a single LED maps onto itself.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      rot[(i + 1) % NUM_LEDS] = LED[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      MODE     <= MODE_OFF;
      led_mode <= MODE_OFF;
      LED      <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      if (MODE > MODE_LAST) begin
        MODE <= MODE_OFF;
      end else if (PRESS) begin
        MODE <= next_mode(MODE);
      end

      // Restart the step period whenever the mode is about to change.
      if (PRESS || (MODE > MODE_LAST) || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      // LEDs trail MODE by one cycle; a mismatch means "entering a new mode".
      if (MODE != led_mode) begin
        led_mode <= MODE;
        pwm_cnt  <= '0;
        case (MODE)
          MODE_ON, MODE_BLINK: LED <= '1;
          MODE_CHASE:          LED <= NUM_LEDS'(1);
          MODE_DIM:            LED <= {NUM_LEDS{DUTY != '0}};
          default:             LED <= '0;
        endcase
      end else begin
        pwm_cnt <= pwm_nxt;
        case (MODE)
          MODE_ON:    LED <= '1;
          // A tick that lands with a pending press is dropped; the new mode wins.
          MODE_BLINK: if (tick && !PRESS) LED <= ~LED;
          MODE_CHASE: if (tick && !PRESS) LED <= rot;
          MODE_DIM:   LED <= {NUM_LEDS{({1'b0, pwm_nxt} < DUTY)}};
          default:    LED <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// tb/tb_led_ctrl_multi.sv - self-checking bench for led_ctrl_multi
module tb_led_ctrl_multi;

  localparam int NL   = 4;
  localparam int DB   = 4;
  localparam int TICK = 8;
  localparam int PB   = 2;
  localparam int DUTY = 1;

  logic          clk;
  logic          resetn;
  logic          pb;
  logic [NL-1:0] led;
  logic [2:0]    mode;
  logic          press;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  led_ctrl_multi #(
    .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DB), .TICK_CYCLES(TICK),
    .PWM_BITS(PB), .PWM_DUTY(DUTY)
  ) dut (
    .CLK(clk), .RESETn(resetn), .PB_SW(pb),
    .LED(led), .MODE(mode), .PRESS(press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: the button is accepted after DB+1 consecutive disagreeing
  // samples (seen two clocks late); the mode advances the edge after a press;
  // the LED pattern is a function of mode, edges since entry and ticks seen.
  int         m_mode, m_led_mode, m_entry, m_clr, m_ticks, m_run;
  logic       m_deb, m_press, m_valid = 1'b0;
  logic       m_d1, m_d2;
  logic [3:0] m_led;

  function automatic logic [3:0] led_of(input int md, input int k, input int ticks);
    case (md)
      1:       return 4'hF;
      2:       return (ticks % 2 == 0) ? 4'hF : 4'h0;
      3:       return 4'(1 << (ticks % 4));
      4:       return ((k % (1 << PB)) < DUTY) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic s, prev_press;
    cyc++;
    if (!resetn) begin
      m_mode = 0; m_led_mode = 0; m_entry = cyc; m_clr = cyc; m_ticks = 0;
      m_run = 0; m_deb = 1'b1; m_press = 1'b0; m_d1 = 1'b1; m_d2 = 1'b1;
      m_led = 4'h0; m_valid = 1'b1;
    end else if (m_valid) begin
      s = m_d2; m_d2 = m_d1; m_d1 = pb;
      prev_press = m_press;
      m_press = 1'b0;
      if (s != m_deb) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_deb = s; m_run = 0; m_press = (s == 1'b0);
        end
      end else begin
        m_run = 0;
      end
      if (m_mode != m_led_mode) begin
        m_led_mode = m_mode; m_entry = cyc; m_ticks = 0;
      end else if (((cyc - m_clr) % TICK) == 0 && !prev_press) begin
        m_ticks++;
      end
      m_led = led_of(m_led_mode, cyc - m_entry, m_ticks);
      if (prev_press) begin
        m_mode = (m_mode + 1) % 5; m_clr = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_led", led, m_led);
      chk("model_mode", mode, m_mode);
      chk("model_press", press, m_press);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(output int pe);
    pe = -1;
    pb = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (press === 1'b1) begin
        pe = cyc;
        break;
      end
    end
    if (pe < 0) begin
      n_checks++; n_errors++;
      $display("FAIL press_timeout at cycle %0d: got no PRESS, expected one within 20 cycles", cyc);
    end
    pb = 1'b1;
  endtask

  initial begin
    int n0, pe, x;
    resetn = 1'b0;
    pb     = 1'b1;
    step(3);
    chk("reset_led", led, 4'h0);
    chk("reset_mode", mode, 3'd0);
    chk("reset_press", press, 1'b0);
    resetn = 1'b1;
    step(5);
    chk("idle_led", led, 4'h0);
    chk("idle_mode", mode, 3'd0);

    // First press: latency and single pulse while held.
    pb = 1'b0;
    step(1);
    n0 = cyc;
    step(5);
    chk("press_n5", press, 1'b0);
    step(1);
    chk("press_n6", press, 1'b1);
    step(1);
    chk("mode_n7", mode, 3'd1);
    chk("press_n7", press, 1'b0);
    step(1);
    chk("led_n8", led, 4'hF);
    chk("edge_count", cyc - n0, 8);
    step(100);
    chk("hold_mode", mode, 3'd1);
    pb = 1'b1;
    step(10);

    // Bounce: never stable long enough.
    for (int r = 0; r < 5; r++) begin
      pb = 1'b0; step(3);
      pb = 1'b1; step(1);
    end
    step(10);
    chk("bounce_mode", mode, 3'd1);

    // BLINK
    press_btn(pe);
    step(2);  chk("blink_entry", led, 4'hF);
    step(6);  chk("blink_p8", led, 4'hF);
    step(1);  chk("blink_p9", led, 4'h0);
    step(8);  chk("blink_p17", led, 4'hF);
    step(4);

    // CHASE
    press_btn(pe);
    step(2);  chk("chase_entry", led, 4'h1);
    step(7);  chk("chase_p9", led, 4'h2);
    step(8);  chk("chase_p17", led, 4'h4);
    step(8);  chk("chase_p25", led, 4'h8);
    step(8);  chk("chase_p33", led, 4'h1);
    step(4);

    // DIM
    press_btn(pe);
    step(2);  chk("dim_p2", led, 4'hF);
    step(1);  chk("dim_p3", led, 4'h0);
    step(2);  chk("dim_p5", led, 4'h0);
    step(1);  chk("dim_p6", led, 4'hF);
    step(10);

    // DIM -> OFF, then wrap to ON
    press_btn(pe);
    step(1);  chk("off_mode", mode, 3'd0);
    step(1);  chk("off_led", led, 4'h0);
    step(10);
    press_btn(pe);
    step(1);  chk("wrap_mode", mode, 3'd1);
    step(10);

    // Into CHASE, then reset with the debounce counter mid-count.
    press_btn(pe);
    step(10);
    press_btn(pe);
    step(12);
    chk("pre_reset_mode", mode, 3'd3);
    pb = 1'b0;
    step(3);
    resetn = 1'b0;
    step(1);
    x = cyc;
    chk("midreset_led", led, 4'h0);
    chk("midreset_mode", mode, 3'd0);
    chk("midreset_press", press, 1'b0);
    resetn = 1'b1;
    press_btn(pe);
    chk("held_through_reset_latency", pe - x, 7);
    step(1);
    chk("held_through_reset_mode", mode, 3'd1);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish before 100000 ns", cyc);
    $fatal(1, "watchdog");
  end

endmodule
